jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Modulo-N synchronous up/down counter built as a bank of WIDTH JK flip-flop cells.
- A per-bit excitation encoder computes the J/K drive for each cell from the current and desired next state, so each cell updates only through JK semantics.
- Used as a reusable counter and sequencer primitive alongside the team's flip-flop conversion blocks. The J/K vectors are exported so benches can check the encoder directly.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥ 1.
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable: one step per clk when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  counter state (JK cell Q outputs).
- qbar  output  WIDTH  bitwise complement of q, driven from each cell's own Qbar register.
- tc  output  1  terminal count (combinational from q and up).
- wrap  output  1  registered one-cycle pulse marking a wrap.
- jk_j  output  WIDTH  current J drive per cell (combinational).
- jk_k  output  WIDTH  current K drive per cell (combinational).

Behaviour:
- Reset (rst_n low, asynchronous):
  - q = 0, qbar = all ones, wrap = 0.
  - Release is synchronous to the next clk edge. Reset mid-count discards the count immediately.
- Each bit is a JK cell with the standard table: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle. Q and Qbar are both registers updated on the same edge; they must always be complements.
- Next-state selection, highest priority first:
  1. load=1: nxt = load_val, or MODULUS-1 if load_val ≥ MODULUS.
  2. en=1 and up=1: nxt = (q == MODULUS-1) ? 0 : q+1.
  3. en=1 and up=0: nxt = (q == 0) ? MODULUS-1 : q-1.
  4. Otherwise: nxt = q.
- Excitation encoder, per bit i (don't-cares resolved to 0, so toggle code 11 is never produced):
  - q[i]=0, nxt[i]=0 -> J=0, K=0.
  - q[i]=0, nxt[i]=1 -> J=1, K=0.
  - q[i]=1, nxt[i]=0 -> J=0, K=1.
  - q[i]=1, nxt[i]=1 -> J=0, K=0.
- Consequence of the encoder rules: jk_j & jk_k == 0 always, and when idle (no load, no en) jk_j = jk_k = 0.
- Latency: q reflects a load or step one clk after the request is sampled.
- tc:
  - 1 when up=1 and q == MODULUS-1.
  - 1 when up=0 and q == 0.
  - Independent of en.
- wrap: registered. Set to 1 on the edge where en=1, load=0 and tc=1 (i.e. a wrap occurs). Otherwise 0. A load never asserts wrap.
- Simultaneous load and en: load wins, no step occurs, wrap = 0.
- Direction change mid-count takes effect on the next enabled edge. No extra cycles.
- The arithmetic for q±1 is evaluated at WIDTH+1 bits, so there is no silent overflow when MODULUS = 2^WIDTH.

Optional Feature:
- Macro: JK_SATURATE_EN.
- Defined:
  - Counting up at MODULUS-1 holds at MODULUS-1; counting down at 0 holds at 0. Excitation is all zeros in both cases.
  - wrap is never asserted. tc behaves as above, acting as a "saturated" flag.
- Not defined: modulo wrap-around as specified in Behaviour.

Test Plan:
- Reset: drive rst_n=0 mid-count (q=6) with no clk edge -> q=0, qbar=4'b1111, wrap=0 immediately. Hold low across edges -> values unchanged.
- Up count: en=1, up=1 from 0 for 12 clks -> q sequence 1..9,0,1,2. tc=1 while q=9. wrap pulses exactly one cycle, after the 9->0 edge. At q=7->8 the drive is jk_j=4'b1000, jk_k=4'b0111.
- Down count: en=1, up=0 from 0 -> q=9,8,7. tc=1 at q=0. wrap pulses after the 0->9 edge. At q=0 the drive is jk_j=4'b1001, jk_k=4'b0000.
- Load priority and clamp:
  - load=1, en=1, load_val=5 -> q=5 next cycle, wrap=0.
  - load_val=13 -> q=9.
  - Idle cycles -> q stable, jk_j=jk_k=0.
- Invariants, random en/up/load for 2000 clks against a reference model:
  - q < MODULUS at all times.
  - qbar == ~q at all times.
  - (jk_j & jk_k) == 0 at all times.
- With JK_SATURATE_EN defined: up from 8 for 3 clks -> q=9,9,9, wrap never 1. Down from 1 for 3 clks -> q=0,0,0.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK flip-flop cells driven by an excitation encoder.
// Optional JK_SATURATE_EN: clamp at the ends of the range instead of wrapping; wrap is then never asserted.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             wrap_nxt;

  // Step arithmetic carries one extra bit so MODULUS == 2**WIDTH cannot alias to zero.
  always_comb begin
    inc_ext = {1'b0, q} + (WIDTH+1)'(1);
    dec_ext = {1'b0, q} - (WIDTH+1)'(1);
    nxt     = q;
    if (load) begin
      nxt = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
`ifdef JK_SATURATE_EN
        if (inc_ext != MOD_EXT) nxt = inc_ext[WIDTH-1:0];
`else
        nxt = (inc_ext == MOD_EXT) ? '0 : inc_ext[WIDTH-1:0];
`endif
      end else begin
`ifdef JK_SATURATE_EN
        if (!dec_ext[WIDTH]) nxt = dec_ext[WIDTH-1:0];
`else
        nxt = dec_ext[WIDTH] ? MAX_VAL : dec_ext[WIDTH-1:0];
`endif
      end
    end
  end

  // Don't-cares resolve to 0, so the toggle code is never issued.
  assign jk_j = ~q & nxt;
  assign jk_k = q & ~nxt;

  assign tc = up ? (q == MAX_VAL) : (q == '0);

`ifdef JK_SATURATE_EN
  assign wrap_nxt = 1'b0;
`else
  assign wrap_nxt = en & ~load & tc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= wrap_nxt;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic q_r;
    logic qbar_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r    <= 1'b0;
        qbar_r <= 1'b1;
      end else begin
        case ({jk_j[i], jk_k[i]})
          2'b01: begin
            q_r    <= 1'b0;
            qbar_r <= 1'b1;
          end
          2'b10: begin
            q_r    <= 1'b1;
            qbar_r <= 1'b0;
          end
          2'b11: begin
            q_r    <= ~q_r;
            qbar_r <= ~qbar_r;
          end
          default: begin
            q_r    <= q_r;
            qbar_r <= qbar_r;
          end
        endcase
      end
    end

    assign q[i]    = q_r;
    assign qbar[i] = qbar_r;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: arithmetic reference model checked every cycle, plus directed literal checks.
module tb_jk_mod_counter;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q, qbar, jk_j, jk_k;
  logic         tc, wrap;

  int  checks = 0;
  int  failures = 0;
  bit  ready = 1'b0;
  int  m_q = 0;
  bit  m_wrap = 1'b0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .qbar(qbar), .tc(tc), .wrap(wrap), .jk_j(jk_j), .jk_k(jk_k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_nxt(input int cq, input bit e, input bit u, input bit l, input int lv);
    if (l) return (lv >= MOD) ? MOD - 1 : lv;
    if (!e) return cq;
`ifdef JK_SATURATE_EN
    if (u) return (cq == MOD - 1) ? cq : cq + 1;
    return (cq == 0) ? 0 : cq - 1;
`else
    if (u) return (cq + 1) % MOD;
    return (cq + MOD - 1) % MOD;
`endif
  endfunction

  function automatic bit model_wrap(input int cq, input bit e, input bit u, input bit l);
`ifdef JK_SATURATE_EN
    return 1'b0;
`else
    return e && !l && ((u && cq == MOD - 1) || (!u && cq == 0));
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = model_wrap(m_q, en, up, load);
      m_q    = model_nxt(m_q, en, up, load, int'(load_val));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (ready) begin
      int nx;
      nx = model_nxt(m_q, en, up, load, int'(load_val));
      chk("q_model",    int'(q),    m_q);
      chk("qbar_model", int'(qbar), (~m_q) & 15);
      chk("wrap_model", int'(wrap), int'(m_wrap));
      chk("tc_model",   int'(tc),   int'(up ? (m_q == MOD - 1) : (m_q == 0)));
      chk("jkj_model",  int'(jk_j), (~m_q) & nx & 15);
      chk("jkk_model",  int'(jk_k), m_q & (~nx) & 15);
      chk("q_range",    int'(int'(q) < MOD), 1);
      chk("jk_excl",    int'(jk_j & jk_k), 0);
    end
  end

  task automatic step(input bit e, input bit u, input bit l, input int lv);
    en = e; up = u; load = l; load_val = W'(lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset_q", int'(q), 0);
    chk("reset_qbar", int'(qbar), 15);
    chk("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    ready = 1'b1;

    step(1'b0, 1'b0, 1'b1, 6);
    chk("load6", int'(q), 6);
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_qbar", int'(qbar), 15);
    chk("async_rst_wrap", int'(wrap), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_q", int'(q), 0);
    chk("rst_hold_qbar", int'(qbar), 15);
    en = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0);
    chk("post_rst_q", int'(q), 0);

`ifdef JK_SATURATE_EN
    step(1'b0, 1'b1, 1'b1, 8);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      chk("sat_up_q", int'(q), 9);
      chk("sat_up_wrap", int'(wrap), 0);
    end
    step(1'b0, 1'b0, 1'b1, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 0);
      chk("sat_dn_q", int'(q), 0);
      chk("sat_dn_wrap", int'(wrap), 0);
    end
    #1;
    chk("sat_dn_jkj", int'(jk_j), 0);
    chk("sat_dn_jkk", int'(jk_k), 0);
    chk("sat_dn_tc", int'(tc), 1);
`else
    for (int k = 1; k <= 12; k++) begin
      en = 1'b1; up = 1'b1; load = 1'b0;
      #1;
      if (k == 8) begin
        chk("up7_jkj", int'(jk_j), 4'b1000);
        chk("up7_jkk", int'(jk_k), 4'b0111);
      end
      chk("up_tc", int'(tc), int'(k == 10));
      @(posedge clk);
      #1;
      chk("up_q", int'(q), k % 10);
      chk("up_wrap", int'(wrap), int'(k == 10));
    end

    step(1'b0, 1'b0, 1'b1, 0);
    en = 1'b1; up = 1'b0; load = 1'b0;
    #1;
    chk("dn0_jkj", int'(jk_j), 4'b1001);
    chk("dn0_jkk", int'(jk_k), 4'b0000);
    chk("dn0_tc", int'(tc), 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("dn_q", int'(q), 10 - k);
      chk("dn_wrap", int'(wrap), int'(k == 1));
    end

    step(1'b0, 1'b1, 1'b1, 13);
    chk("clamp_q", int'(q), 9);
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
    #1;
    chk("pri_tc", int'(tc), 1);
    @(posedge clk);
    #1;
    chk("pri_q", int'(q), 5);
    chk("pri_wrap", int'(wrap), 0);
    en = 1'b0; load = 1'b0;
    #1;
    chk("idle_jkj", int'(jk_j), 0);
    chk("idle_jkk", int'(jk_k), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      chk("idle_q", int'(q), 5);
    end
`endif

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end

    ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
